// File: rtl/wb_bram_b3_if.sv
// Wishbone B3 bus bundle for wb_bram_b3; signal names follow the slave's point of view.
interface wb_bram_b3_if #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32
) ();
  logic [aw-1:0]   wb_adr_i;
  logic [dw-1:0]   wb_dat_i;
  logic [dw/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic [1:0]      wb_bte_i;
  logic [2:0]      wb_cti_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;
  logic [dw-1:0]   wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/wb_bram_b3.sv
// Wishbone B3 slave RAM on a registered-read block RAM: classic cycles plus zero-wait
// constant/incrementing/wrap bursts. memory_file is accepted but the array powers up uninitialised.
module wb_bram_b3 #(
  parameter int unsigned dw             = 32,
  parameter int unsigned aw             = 32,
  parameter int unsigned mem_size_bytes = 32768,
  parameter int unsigned mem_adr_width  = 15,
  parameter string       memory_file    = ""
) (
  input logic         wb_clk_i,
  input logic         wb_rst_i,
  wb_bram_b3_if.slave wb
);

  localparam int unsigned SelW     = dw / 8;
  localparam int unsigned ByteBits = $clog2(SelW);
  localparam int unsigned IdxW     = mem_adr_width - ByteBits;
  localparam int unsigned MemWords = mem_size_bytes / SelW;

  typedef enum logic [1:0] {StIdle, StClassic, StBurst, StErr} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [dw-1:0]   rd_q, rd_d;

  logic [dw-1:0]   mem [MemWords];

  logic            req;
  logic [IdxW-1:0] adr_idx;
  logic            adr_hi;
  logic            addr_err;
  logic            adr_match;
  logic            burst_cti;
  logic [IdxW-1:0] cnt_nxt;
  logic            rd_en;
  logic [IdxW-1:0] rd_idx;
  logic            wr_en;
  logic            unused_adr;

  assign req       = wb.wb_cyc_i & wb.wb_stb_i;
  assign adr_idx   = wb.wb_adr_i[mem_adr_width-1:ByteBits];
  assign adr_hi    = |wb.wb_adr_i[aw-5:mem_adr_width];
  assign addr_err  = req & adr_hi;
  assign adr_match = (adr_idx == cnt_q) & ~adr_hi;
  assign burst_cti = (wb.wb_cti_i == 3'b001) || (wb.wb_cti_i == 3'b010);
  // Top nibble aliases and the byte offset is carried by sel.
  assign unused_adr = ^{wb.wb_adr_i[aw-1:aw-4], wb.wb_adr_i[ByteBits-1:0]};

  // Address of the beat after the current one, from the cycle type sampled this beat.
  always_comb begin
    cnt_nxt = cnt_q;
    if (wb.wb_cti_i != 3'b001) begin
      case (wb.wb_bte_i)
        2'b00:   cnt_nxt = (cnt_q == IdxW'(MemWords - 1)) ? '0 : cnt_q + IdxW'(1);
        2'b01:   cnt_nxt[1:0] = cnt_q[1:0] + 2'd1;
        2'b10:   cnt_nxt[2:0] = cnt_q[2:0] + 3'd1;
        default: cnt_nxt[3:0] = cnt_q[3:0] + 4'd1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (addr_err) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            rd_en   = 1'b1;
            rd_idx  = adr_idx;
            cnt_d   = adr_idx;
            ack_d   = 1'b1;
            state_d = burst_cti ? StBurst : StClassic;
          end
        end
      end
      StClassic: begin
        wr_en   = req & wb.wb_we_i;
        state_d = StIdle;
      end
      StBurst: begin
        if (!wb.wb_cyc_i) begin
          state_d = StIdle;
        end else if (wb.wb_stb_i) begin
          if (!adr_match) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (ack_q) begin
            wr_en = wb.wb_we_i;
            if (wb.wb_cti_i == 3'b111) begin
              state_d = StIdle;
            end else begin
              cnt_d  = cnt_nxt;
              rd_en  = 1'b1;
              rd_idx = cnt_nxt;
              ack_d  = 1'b1;
            end
          end else begin
            // Strobe came back after a gap: re-fetch the held word before acking.
            rd_en = 1'b1;
            ack_d = 1'b1;
          end
        end
      end
      StErr: begin
        state_d = StIdle;
      end
    endcase
  end

  // Write-first per byte so a constant burst sees its own freshly written bytes.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      for (int b = 0; b < int'(SelW); b++) begin
        if (wr_en && wb.wb_sel_i[b] && (rd_idx == cnt_q)) begin
          rd_d[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
        end else begin
          rd_d[8*b +: 8] = mem[rd_idx][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    for (int b = 0; b < int'(SelW); b++) begin
      if (wr_en && wb.wb_sel_i[b]) begin
        mem[cnt_q][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // A predicted burst ack is withheld while the master's address disagrees with the counter.
  assign wb.wb_ack_o = ack_q & ((state_q != StBurst) | adr_match);
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = rd_q;

endmodule

// File: tb/tb_wb_bram_b3.sv
// Self-checking bench for wb_bram_b3: directed bus scenarios plus random bursts against a word model.
module tb_wb_bram_b3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bram_b3_if #(.dw(DW), .aw(AW)) bus ();

  wb_bram_b3 #(
    .dw(DW), .aw(AW), .mem_size_bytes(32768), .mem_adr_width(15), .memory_file("")
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [64];

  logic [31:0] b_adr [16];
  logic [31:0] b_dat [16];
  logic [31:0] b_rd  [16];
  logic        b_we  [16];
  logic [3:0]  b_sel [16];
  logic [2:0]  b_cti [16];
  logic        b_gap [16];
  logic [1:0]  b_bte;
  int          b_n, b_nack, b_lat, b_last, b_errc;
  logic        b_err, b_both, b_done;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;
    bus.wb_cti_i = '0;   bus.wb_bte_i = '0;
  endtask

  task automatic drive_beat(input int k);
    bus.wb_cyc_i = 1'b1;     bus.wb_stb_i = 1'b1;     bus.wb_adr_i = b_adr[k];
    bus.wb_dat_i = b_dat[k]; bus.wb_sel_i = b_sel[k]; bus.wb_we_i  = b_we[k];
    bus.wb_cti_i = b_cti[k]; bus.wb_bte_i = b_bte;
  endtask

  // Master side of one bus cycle; called and returns 1 time unit after a rising edge.
  task automatic run_bus();
    int beat;
    bit gap_taken;
    beat = 0; gap_taken = 0;
    b_nack = 0; b_lat = -1; b_last = -1; b_errc = -1;
    b_err = 1'b0; b_both = 1'b0; b_done = 1'b0;
    drive_beat(0);
    for (int c = 0; c < 64; c++) begin
      #1;
      if (bus.wb_ack_o && bus.wb_err_o) b_both = 1'b1;
      if (bus.wb_stb_i && bus.wb_ack_o) begin
        if (b_lat < 0) b_lat = c;
        b_rd[beat] = bus.wb_dat_o;
        b_nack++;
        b_last = c;
        beat++;
        gap_taken = 0;
      end else if (bus.wb_err_o) begin
        b_err = 1'b1;
        b_errc = c;
      end
      @(posedge clk); #1;
      if (b_err || beat == b_n) begin
        b_done = 1'b1;
        break;
      end
      if (b_gap[beat] && !gap_taken) begin
        bus.wb_stb_i = 1'b0;
        gap_taken = 1;
      end else begin
        drive_beat(beat);
      end
    end
    idle_bus();
  endtask

  task automatic single(input logic [31:0] a, input logic we, input logic [31:0] d,
                        input logic [3:0] s);
    b_n = 1; b_bte = 2'b00;
    b_adr[0] = a; b_we[0] = we; b_dat[0] = d; b_sel[0] = s; b_cti[0] = 3'b000; b_gap[0] = 0;
    run_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.wb_ack_o); end
    checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.wb_err_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.wb_dat_o); end
    checks++; if (bus.wb_rty_o !== 1'b0) begin errors++; $display("FAIL reset_rty: got %b want 0", bus.wb_rty_o); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int w;
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom;
      single(i * 4, 1'b1, model[i], 4'hF);
    end
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(0, 63);
      single(w * 4, 1'b0, 32'h0, 4'h0);
      checks++; if (b_rd[0] !== model[w]) begin errors++; $display("FAIL fill_read w%0d: got %h want %h", w, b_rd[0], model[w]); end
      checks++; if (b_lat !== 1) begin errors++; $display("FAIL fill_lat: got %0d want 1", b_lat); end
    end
  endtask

  task automatic test_classic();
    single(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    model[4] = 32'hDEADBEEF;
    checks++; if (b_lat !== 1 || b_nack !== 1) begin errors++; $display("FAIL classic_wr_ack: lat %0d acks %0d want 1 1", b_lat, b_nack); end
    #1;
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL classic_gap_ack: got %b want 0", bus.wb_ack_o); end
    single(32'h10, 1'b0, 32'h0, 4'hF);
    checks++; if (b_lat !== 1) begin errors++; $display("FAIL classic_rd_lat: got %0d want 1", b_lat); end
    checks++; if (b_rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_dat: got %h want deadbeef", b_rd[0]); end
    single(32'h10, 1'b1, 32'h0000AA00, 4'b0010);
    model[4] = merge(model[4], 32'h0000AA00, 4'b0010);
    single(32'h10, 1'b0, 32'h0, 4'hF);
    checks++; if (b_rd[0] !== 32'hDEADAAEF) begin errors++; $display("FAIL byte_sel: got %h want deadaaef", b_rd[0]); end
  endtask

  task automatic test_wrap_burst();
    logic [31:0] want [4];
    for (int i = 4; i < 8; i++) begin
      single(i * 4, 1'b1, i, 4'hF);
      model[i] = i;
    end
    want[0] = 6; want[1] = 7; want[2] = 4; want[3] = 5;
    b_n = 4; b_bte = 2'b01;
    b_adr[0] = 32'h18; b_adr[1] = 32'h1C; b_adr[2] = 32'h10; b_adr[3] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      b_we[i] = 1'b0; b_dat[i] = '0; b_sel[i] = 4'hF; b_gap[i] = 0;
      b_cti[i] = (i == 3) ? 3'b111 : 3'b010;
    end
    run_bus();
    checks++; if (b_lat !== 1) begin errors++; $display("FAIL wrap_lat: got %0d want 1", b_lat); end
    checks++; if (b_nack !== 4 || b_last !== 4) begin errors++; $display("FAIL wrap_acks: acks %0d last %0d want 4 4", b_nack, b_last); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_rd[i] !== want[i]) begin errors++; $display("FAIL wrap_dat beat%0d: got %h want %h", i, b_rd[i], want[i]); end
    end
    single(32'h14, 1'b0, 32'h0, 4'hF);
    checks++; if (b_lat !== 1 || b_rd[0] !== 32'h5) begin errors++; $display("FAIL wrap_idle_after: lat %0d dat %h want 1 5", b_lat, b_rd[0]); end
  endtask

  task automatic test_burst_mismatch();
    b_n = 3; b_bte = 2'b00;
    b_adr[0] = 32'h00; b_adr[1] = 32'h04; b_adr[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      b_we[i] = (i == 2); b_dat[i] = ~model[8]; b_sel[i] = 4'hF; b_cti[i] = 3'b010; b_gap[i] = 0;
    end
    run_bus();
    checks++; if (b_nack !== 2) begin errors++; $display("FAIL mismatch_acks: got %0d want 2", b_nack); end
    checks++; if (b_err !== 1'b1 || b_errc !== 4) begin errors++; $display("FAIL mismatch_err: err %b cycle %0d want 1 4", b_err, b_errc); end
    checks++; if (b_rd[0] !== model[0] || b_rd[1] !== model[1]) begin errors++; $display("FAIL mismatch_dat: got %h %h want %h %h", b_rd[0], b_rd[1], model[0], model[1]); end
    checks++; if (b_both !== 1'b0) begin errors++; $display("FAIL mismatch_ack_err_overlap: got %b want 0", b_both); end
    #1;
    checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL mismatch_err_len: got %b want 0", bus.wb_err_o); end
    single(32'h20, 1'b0, 32'h0, 4'hF);
    checks++; if (b_rd[0] !== model[8]) begin errors++; $display("FAIL mismatch_word8: got %h want %h", b_rd[0], model[8]); end
  endtask

  task automatic test_const_burst();
    b_n = 3; b_bte = 2'b00;
    for (int i = 0; i < 3; i++) begin
      b_adr[i] = 32'h30; b_gap[i] = 0; b_cti[i] = (i == 2) ? 3'b111 : 3'b001;
    end
    b_we[0] = 1'b1; b_dat[0] = 32'h11;       b_sel[0] = 4'hF;
    b_we[1] = 1'b1; b_dat[1] = 32'h0000AB00; b_sel[1] = 4'b0010;
    b_we[2] = 1'b0; b_dat[2] = 32'h0;        b_sel[2] = 4'hF;
    run_bus();
    model[12] = 32'h0000AB11;
    checks++; if (b_nack !== 3 || b_last !== 3) begin errors++; $display("FAIL const_acks: acks %0d last %0d want 3 3", b_nack, b_last); end
    checks++; if (b_rd[1] !== 32'h11) begin errors++; $display("FAIL const_bypass_full: got %h want 00000011", b_rd[1]); end
    checks++; if (b_rd[2] !== 32'h0000AB11) begin errors++; $display("FAIL const_bypass_byte: got %h want 0000ab11", b_rd[2]); end
  endtask

  task automatic test_addr_err();
    single(32'h0010_0000, 1'b1, ~model[0], 4'hF);
    checks++; if (b_err !== 1'b1 || b_errc !== 1) begin errors++; $display("FAIL adr_err: err %b cycle %0d want 1 1", b_err, b_errc); end
    checks++; if (b_nack !== 0) begin errors++; $display("FAIL adr_err_ack: got %0d want 0", b_nack); end
    #1;
    checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL adr_err_len: got %b want 0", bus.wb_err_o); end
    single(32'h0, 1'b0, 32'h0, 4'hF);
    checks++; if (b_rd[0] !== model[0]) begin errors++; $display("FAIL adr_err_mem: got %h want %h", b_rd[0], model[0]); end
  endtask

  task automatic test_random_bursts();
    logic [31:0] want [16];
    bit          chk  [16];
    int s, n, wrap, gaps, word;
    bit cnst;
    for (int it = 0; it < 24; it++) begin
      b_bte = 2'($urandom_range(0, 3));
      cnst  = ($urandom_range(0, 3) == 0);
      wrap  = (b_bte == 2'b01) ? 4 : (b_bte == 2'b10) ? 8 : (b_bte == 2'b11) ? 16 : 0;
      s     = $urandom_range(0, 40);
      n     = $urandom_range(1, 8);
      b_n   = n;
      gaps  = 0;
      for (int i = 0; i < n; i++) begin
        if (cnst)           word = s;
        else if (wrap == 0) word = s + i;
        else                word = (s / wrap) * wrap + (s + i) % wrap;
        b_adr[i] = word * 4;
        b_we[i]  = 1'($urandom_range(0, 1));
        b_dat[i] = $urandom;
        b_sel[i] = 4'($urandom_range(1, 15));
        b_cti[i] = (i == n - 1) ? 3'b111 : (cnst ? 3'b001 : 3'b010);
        b_gap[i] = (i > 0) && ($urandom_range(0, 3) == 0);
        if (b_gap[i]) gaps++;
        chk[i]  = !b_we[i];
        want[i] = model[word];
        if (b_we[i]) model[word] = merge(model[word], b_dat[i], b_sel[i]);
      end
      run_bus();
      checks++; if (b_done !== 1'b1 || b_nack !== n) begin errors++; $display("FAIL rnd%0d_acks: done %b acks %0d want 1 %0d", it, b_done, b_nack, n); end
      checks++; if (b_lat !== 1 || b_last !== n + 2 * gaps) begin errors++; $display("FAIL rnd%0d_timing: first %0d last %0d want 1 %0d", it, b_lat, b_last, n + 2 * gaps); end
      checks++; if (b_both !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_err: overlap %b err %b want 0 0", it, b_both, b_err); end
      for (int i = 0; i < n; i++) begin
        if (chk[i]) begin
          checks++; if (b_rd[i] !== want[i]) begin errors++; $display("FAIL rnd%0d_dat beat%0d: got %h want %h", it, i, b_rd[i], want[i]); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 32'h0;
    bus.wb_we_i = 1'b0;  bus.wb_sel_i = 4'hF; bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b00;
    @(posedge clk); #1;
    #1;
    checks++; if (bus.wb_ack_o !== 1'b1) begin errors++; $display("FAIL arst_pre_ack: got %b want 1", bus.wb_ack_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL arst_async: ack %b err %b want 0 0", bus.wb_ack_o, bus.wb_err_o); end
    idle_bus();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    single(32'h14, 1'b0, 32'h0, 4'hF);
    checks++; if (b_lat !== 1 || b_rd[0] !== model[5]) begin errors++; $display("FAIL arst_after: lat %0d dat %h want 1 %h", b_lat, b_rd[0], model[5]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_classic();
    test_wrap_burst();
    test_burst_mismatch();
    test_const_burst();
    test_addr_err();
    test_random_bursts();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
